// File: rtl/spi_pkg.sv
// spi_pkg: op encodings, widths and FSM states shared by the SPI master files
package spi_pkg;
    localparam int FRAME_W = 10;
    localparam int DATA_W = 8;
    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;
    typedef enum logic [2:0] {ST_IDLE, ST_CTRL, ST_SHIFT, ST_WAIT, ST_READ, ST_GAP} state_t;
endpackage

// File: rtl/spi_shift_reg.sv
// spi_shift_reg: loadable MSB-first shifter with serial-in, used for TX frame and RX byte
module spi_shift_reg
    import spi_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               shift_en,
    input  logic               si,
    input  logic [FRAME_W-1:0] d,
    output logic [FRAME_W-1:0] q
);
    always_ff @(posedge clk)
        q <= rst ? '0 : load ? d : shift_en ? {q[FRAME_W-2:0], si} : q;
endmodule

// File: rtl/spi_master_driver.sv
// spi_master_driver: SPI frame master (op+payload out on MOSI, read byte in from MISO); SPI_MASTER_STATS_EN adds wr_cnt/rd_cnt
module spi_master_driver
    import spi_pkg::*;
#(
    parameter int RD_WAIT = 2,
    parameter int GAP = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic              SS_n,
    output logic              MOSI,
    input  logic              MISO
`ifdef SPI_MASTER_STATS_EN
    ,
    output logic [15:0]       wr_cnt,
    output logic [15:0]       rd_cnt
`endif
);
    if (RD_WAIT < 1 || RD_WAIT > 15 || GAP < 1 || GAP > 15) begin : g_bad_param
        $error("spi_master_driver: RD_WAIT and GAP must be in 1..15");
    end
    localparam logic [3:0] WAIT_LAST = 4'(RD_WAIT - 1);
    localparam logic [3:0] GAP_LAST = 4'(GAP - 1);
    state_t state, state_nxt;
    logic [3:0] cnt;
    logic [1:0] op;
    logic [FRAME_W-1:0] sr;
    logic accept, sr_unused;
    assign accept = cmd_valid && cmd_ready;
    assign cmd_ready = state == ST_IDLE;
    assign busy = state != ST_IDLE;
    assign SS_n = state == ST_IDLE || state == ST_GAP;
    assign MOSI = (state == ST_CTRL || state == ST_SHIFT) && sr[FRAME_W-1];
    assign sr_unused = ^sr[FRAME_W-2:DATA_W-1];
    spi_shift_reg u_sr (
        .clk     (clk),
        .rst     (rst),
        .load    (accept),
        .shift_en(state == ST_SHIFT || state == ST_READ),
        .si      (state == ST_READ && MISO),
        .d       ({cmd_op, cmd_data}),
        .q       (sr)
    );
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  state_nxt = cmd_valid ? ST_CTRL : ST_IDLE;
            ST_CTRL:  state_nxt = ST_SHIFT;
            ST_SHIFT: state_nxt = cnt == 4'd9 ? (op == OP_RD_DATA ? ST_WAIT : ST_GAP) : ST_SHIFT;
            ST_WAIT:  state_nxt = cnt == WAIT_LAST ? ST_READ : ST_WAIT;
            ST_READ:  state_nxt = cnt == 4'd7 ? ST_GAP : ST_READ;
            ST_GAP:   state_nxt = cnt == GAP_LAST ? ST_IDLE : ST_GAP;
            default:  state_nxt = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt <= '0;
            op <= '0;
            rsp_valid <= 1'b0;
            rsp_data <= '0;
        end else begin
            state <= state_nxt;
            cnt <= state_nxt != state ? 4'd0 : cnt + 4'd1;
            if (accept) op <= cmd_op;
            rsp_valid <= state == ST_READ && cnt == 4'd7;
            if (state == ST_READ && cnt == 4'd7) rsp_data <= {sr[DATA_W-2:0], MISO};
        end
    end
`ifdef SPI_MASTER_STATS_EN
    logic wr_done;
    assign wr_done = state == ST_SHIFT && cnt == 4'd9 && (op == OP_WR_ADDR || op == OP_WR_DATA);
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else begin
            wr_cnt <= wr_cnt + 16'(wr_done);
            rd_cnt <= rd_cnt + 16'(rsp_valid);
        end
    end
`endif
endmodule

// File: doc/spi_master_driver.md
Name: spi_master_driver

Overview:
- Bus-side master that generates SPI frames for the SPI-slave/RAM subsystem on the same clock.
- Accepts one command at a time (2-bit op + 8-bit payload) and serialises it MSB-first on MOSI under SS_n.
- For read-data ops, collects the 8-bit reply from MISO and returns it on a one-cycle response strobe.
- Sits directly upstream of the slave: drives its SS_n/MOSI pins and consumes its MISO.

Parameters:
- RD_WAIT, 2, cycles between the last MOSI bit and the first MISO sample for op 2'b11; legal range 1..15.
- GAP, 1, cycles SS_n is held high after every frame before the next command is accepted; legal range 1..15.

Ports:
- clk  input  1  system clock; all logic on its rising edge
- rst  input  1  synchronous reset, active-high
- cmd_valid  input  1  command request
- cmd_ready  output  1  high only in IDLE; a transfer occurs when cmd_valid && cmd_ready
- cmd_op  input  2  00 write-addr, 01 write-data, 10 read-addr, 11 read-data
- cmd_data  input  8  payload; don't-care for op 11 (sent as captured)
- rsp_valid  output  1  one-cycle pulse carrying read data
- rsp_data  output  8  read byte; holds its value until the next rsp_valid
- busy  output  1  high from the accept cycle+1 through the end of GAP
- SS_n  output  1  slave select, active-low
- MOSI  output  1  serial data to slave
- MISO  input  1  serial data from slave

Behaviour:
- Reset (rst=1 at an edge) values:
  - SS_n=1, MOSI=0, cmd_ready=1, busy=0, rsp_valid=0, rsp_data=8'h00; state=IDLE.
  - Reset mid-frame aborts immediately: SS_n high next edge, no rsp_valid.
- Accept: on a cmd_valid && cmd_ready edge, capture frame = {cmd_op, cmd_data} (10 bits) and go to CTRL. Inputs are not sampled again until IDLE.
- States (SS_n is driven from registers; every state lasts whole cycles):
  - IDLE: SS_n=1, cmd_ready=1.
  - CTRL (1 cycle): SS_n=0, MOSI=frame[9] (read/write select bit). Go to SHIFT.
  - SHIFT (10 cycles): MOSI=frame[9] down to frame[0], one bit per cycle. Next state is WAIT for op 11, otherwise GAP.
  - WAIT (RD_WAIT cycles): SS_n=0, MOSI=0.
  - READ (8 cycles): SS_n=0, MOSI=0; sample MISO each rising edge, shifting left into rx_shift. The first sample is rsp bit 7.
  - GAP (GAP cycles): SS_n=1, MOSI=0. Go to IDLE.
  - On READ→GAP, rsp_data<=rx_shift and rsp_valid=1 for exactly the first GAP cycle.
- Frame lengths (SS_n low):
  - 11 cycles for ops 00/01/10.
  - 19+RD_WAIT cycles for op 11 (21 at default).
- Counters:
  - Bit counter 4 bits; wait/gap counter 4 bits; no wrap possible within legal parameter ranges.
  - Out-of-range parameters fail elaboration via a generate-time check.
- Simultaneous events:
  - cmd_valid while busy is ignored, with no queueing; the command must be held until cmd_ready.
  - rst overrides everything.
- No backpressure on rsp: a missed rsp_valid is lost.
- MISO is ignored outside READ.

Optional Feature:
- Macro SPI_MASTER_STATS_EN.
- Defined: adds output wr_cnt[15:0] and output rd_cnt[15:0].
  - wr_cnt increments when a frame with op 00/01 leaves SHIFT.
  - rd_cnt increments on each rsp_valid.
  - Both wrap 16'hFFFF→0 and reset to 0.
- Undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package spi_pkg:
  - Op encodings OP_WR_ADDR=2'b00, OP_WR_DATA=2'b01, OP_RD_ADDR=2'b10, OP_RD_DATA=2'b11.
  - FRAME_W=10, DATA_W=8.
  - State enum (IDLE, CTRL, SHIFT, WAIT, READ, GAP).
- One natural sub-module: spi_shift_reg, a 10-bit loadable MSB-first shifter with serial-in, reused for both TX frame and RX byte. The FSM stays in the top.

Test Plan:
- Write-addr: op 00, data 8'h3C → SS_n low 11 cycles; MOSI sequence 0,0,0,0,0,1,1,1,1,0,0; then SS_n high 1 cycle; cmd_ready returns after GAP.
- Write-data: op 01, data 8'hA5 → MOSI 0,0,1,1,0,1,0,0,1,0,1; no rsp_valid.
- Read-data with slave model returning 8'h5A → SS_n low 21 cycles; rsp_valid single pulse with rsp_data=8'h5A; rsp_data holds afterwards.
- Back-to-back: cmd_valid held high with ops 10 then 11 → second accept exactly GAP+1 cycles after the first frame ends; cmd_ready=0 throughout frames.
- Reset at the 5th SHIFT cycle of an op 11 → next edge SS_n=1, MOSI=0, busy=0, no rsp_valid; a fresh op 00 then completes normally.
- SPI_MASTER_STATS_EN: 3 writes + 2 read-data → wr_cnt=3, rd_cnt=2; preload to 16'hFFFF via forced write stream → next write gives wr_cnt=0.
